// File: rtl/soc_uart_pkg.sv
// Shared register map, STATUS bit positions and serial FSM state type for the UART slice.
package pck_uart;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    localparam int STAT_TX_FULL   = 0;
    localparam int STAT_TX_EMPTY  = 1;
    localparam int STAT_RX_VALID  = 2;
    localparam int STAT_RX_OVERUN = 3;
    localparam int STAT_RX_FRAME  = 4;
    localparam int STAT_TX_ACTIVE = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // A divider of zero would stall the baud counters, so it behaves as one.
    function automatic logic [15:0] bit_period(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/soc_fifo_sync.sv
// Single-clock FIFO; pointers carry one extra wrap bit so full and empty need no counter.
module soc_fifo_sync #(
    parameter int p_width = 8,
    parameter int p_depth = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               push,
    input  logic [p_width-1:0] wr_data,
    input  logic               pop,
    output logic [p_width-1:0] rd_data,
    output logic               full,
    output logic               empty
);

    localparam int AW = $clog2(p_depth);

    logic [p_width-1:0] mem [p_depth];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               pop_ok;
    logic               push_ok;

    // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/soc_uart.sv
// Memory-mapped 8N1 UART: TX FIFO feeding a serialiser, single-byte RX holding register,
// status flags and a programmable baud divider behind a one-cycle-ack bus slave.
module soc_uart
    import pck_uart::*;
#(
    parameter int p_fifo_depth = 8,
    parameter int p_div_reset  = 868
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_be,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_data,
    input  logic        i_rd_en,
    output logic [31:0] o_rd_data,
    output logic        o_busy,
    output logic        o_ack,
    input  logic        i_rx,
    output logic        o_tx
);

    localparam logic [15:0] DIV_RST = 16'(p_div_reset);

    logic [1:0]  reg_sel;
    logic        tx_push;
    logic        rd_data_reg;
    logic        rd_status;
    logic [15:0] div_q;
    logic [15:0] div_eff;
    logic [31:0] rd_mux;
    logic [5:0]  status;
    logic        unused_bits;

    uart_state_t tx_state;
    logic [15:0] tx_cnt;
    logic [15:0] tx_per;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_q;
    logic        tx_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_rd;

    uart_state_t rx_state;
    logic        rx_s1;
    logic        rx_s2;
    logic        rx_prev;
    logic [15:0] rx_cnt;
    logic [15:0] rx_per;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic [7:0]  rx_hold;
    logic        rx_valid;
    logic        rx_overrun;
    logic        rx_frame_err;

    assign reg_sel     = i_addr[3:2];
    assign tx_push     = i_wr_en && (reg_sel == REG_DATA) && i_be[0];
    assign rd_data_reg = i_rd_en && (reg_sel == REG_DATA);
    assign rd_status   = i_rd_en && (reg_sel == REG_STATUS);
    assign div_eff     = bit_period(div_q);
    assign unused_bits = ^{i_addr[31:4], i_addr[1:0], i_be[3:2], i_wr_data[31:16]};
    assign o_tx        = tx_q;

    // The FIFO is drained either from IDLE or at the last cycle of STOP, which keeps frames gapless.
    assign tx_pop = !fifo_empty && ((tx_state == IDLE) || ((tx_state == STOP) && (tx_cnt == 16'd0)));

    soc_fifo_sync #(
        .p_width (8),
        .p_depth (p_fifo_depth)
    ) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .push    (tx_push),
        .wr_data (i_wr_data[7:0]),
        .pop     (tx_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        status                 = '0;
        status[STAT_TX_FULL]   = fifo_full;
        status[STAT_TX_EMPTY]  = fifo_empty;
        status[STAT_RX_VALID]  = rx_valid;
        status[STAT_RX_OVERUN] = rx_overrun;
        status[STAT_RX_FRAME]  = rx_frame_err;
        status[STAT_TX_ACTIVE] = (tx_state != IDLE);
    end

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_DATA:   rd_mux[7:0]  = rx_valid ? rx_hold : 8'h00;
            REG_STATUS: rd_mux[5:0]  = status;
            REG_DIV:    rd_mux[15:0] = div_q;
            default:    rd_mux       = '0;
        endcase
    end

    // Bus response stage: everything the master sees is registered one cycle after the strobe.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_ack     <= 1'b0;
            o_busy    <= 1'b0;
            o_rd_data <= '0;
            div_q     <= DIV_RST;
        end else begin
            o_ack     <= i_rd_en || i_wr_en;
            o_busy    <= tx_push && fifo_full && !tx_pop;
            o_rd_data <= i_rd_en ? rd_mux : '0;
            if (i_wr_en && (reg_sel == REG_DIV)) begin
                if (i_be[0]) div_q[7:0]  <= i_wr_data[7:0];
                if (i_be[1]) div_q[15:8] <= i_wr_data[15:8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            tx_state <= IDLE;
            tx_q     <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
        end else begin
            case (tx_state)
                IDLE, STOP: begin
                    if (tx_state == STOP && tx_cnt != 16'd0) begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end else if (tx_pop) begin
                        tx_per   <= div_eff;
                        tx_cnt   <= div_eff - 16'd1;
                        tx_shift <= fifo_rd;
                        tx_q     <= 1'b0;
                        tx_state <= START;
                    end else begin
                        tx_state <= IDLE;
                    end
                end
                START: begin
                    if (tx_cnt == 16'd0) begin
                        tx_cnt   <= tx_per - 16'd1;
                        tx_q     <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= '0;
                        tx_state <= DATA;
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (tx_cnt == 16'd0) begin
                        tx_cnt <= tx_per - 16'd1;
                        if (tx_bit == 3'd7) begin
                            tx_q     <= 1'b1;
                            tx_state <= STOP;
                        end else begin
                            tx_q     <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // RX path: sampling points sit half a period after the synchronised falling edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rx_s1        <= 1'b1;
            rx_s2        <= 1'b1;
            rx_prev      <= 1'b1;
            rx_state     <= IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_hold      <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_s1   <= i_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            if (rd_data_reg) begin
                rx_valid   <= 1'b0;
                rx_overrun <= 1'b0;
            end
            if (rd_status) rx_frame_err <= 1'b0;
            case (rx_state)
                IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_per   <= div_eff;
                        rx_cnt   <= div_eff >> 1;
                        rx_state <= START;
                    end
                end
                START: begin
                    if (rx_cnt != 16'd0) begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end else if (rx_s2) begin
                        rx_state <= IDLE;
                    end else begin
                        rx_cnt   <= rx_per - 16'd1;
                        rx_bit   <= '0;
                        rx_state <= DATA;
                    end
                end
                DATA: begin
                    if (rx_cnt != 16'd0) begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end else begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_cnt   <= rx_per - 16'd1;
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= STOP;
                    end
                end
                STOP: begin
                    if (rx_cnt != 16'd0) begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end else begin
                        rx_state <= IDLE;
                        if (rx_s2) begin
                            rx_hold  <= rx_shift;
                            rx_valid <= 1'b1;
                            if (rx_valid && !rd_data_reg) rx_overrun <= 1'b1;
                        end else begin
                            rx_frame_err <= 1'b1;
                        end
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

endmodule
